// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter.
// After reset, sweeps registers 1..NREG-1 to zero (one write per cycle), then
// arbitrates two write requesters round-robin onto a single registered write port.
//
// Handshake: a requester raises req with stable wsel/wdat and holds all three
// until its gnt is seen high in the same cycle; gnt is combinational, and the
// request is consumed at the rising edge that ends that cycle.
module regfile_write_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_req,
  input  logic [AW-1:0] a_wsel,
  input  logic [DW-1:0] a_wdat,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic [AW-1:0] b_wsel,
  input  logic [DW-1:0] b_wdat,
  output logic          b_gnt,
  output logic          init_busy,
  output logic          WEN,
  output logic [AW-1:0] wsel,
  output logic [DW-1:0] wdat,
  output logic          state_dbg
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_ARB  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] sweep_cnt;
  logic          sweep_last;
  logic          last_b;
  logic          arb_en;

  assign sweep_last = (sweep_cnt == AW'(NREG - 1));
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next state: leave the sweep once the last register's clear is issued.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && sweep_last) state_nxt = S_ARB;
  end

  // Grants: round-robin between A and B. Arbitration waits until the final
  // sweep write has left the output registers, and is blocked during reset.
  always_comb begin
    arb_en = (state == S_ARB) && !init_busy && !RST;
    a_gnt  = arb_en && a_req && (!b_req || last_b);
    b_gnt  = arb_en && b_req && (!a_req || !last_b);
  end

  // Sweep counter: walks 1..NREG-1 during INIT.
  always_ff @(posedge CLK) begin
    if (RST)                  sweep_cnt <= AW'(1);
    else if (state == S_INIT) sweep_cnt <= sweep_cnt + AW'(1);
  end

  // Last-grant pointer: starts at B so A wins the first contention.
  always_ff @(posedge CLK) begin
    if (RST)        last_b <= 1'b1;
    else if (a_gnt) last_b <= 1'b0;
    else if (b_gnt) last_b <= 1'b1;
  end

  // Registered write port: sweep writes in INIT, granted writes in ARB.
  // Writes to register 0 are consumed but suppressed; idle cycles hold sel/data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WEN       <= 1'b0;
      wsel      <= '0;
      wdat      <= '0;
      init_busy <= 1'b0;
    end else if (state == S_INIT) begin
      WEN       <= 1'b1;
      wsel      <= sweep_cnt;
      wdat      <= '0;
      init_busy <= 1'b1;
    end else begin
      init_busy <= 1'b0;
      WEN       <= 1'b0;
      if (a_gnt && a_wsel != '0) begin
        WEN  <= 1'b1;
        wsel <= a_wsel;
        wdat <= a_wdat;
      end else if (b_gnt && b_wsel != '0) begin
        WEN  <= 1'b1;
        wsel <= b_wsel;
        wdat <= b_wdat;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: a cycle-level reference model pushes the
// expected write-port contents into a queue; they are popped and compared one
// cycle later, and grants are compared in the cycle they are expected.
module tb_regfile_write_arbiter;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam int P_INIT  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_ARB   = 2;

  logic          CLK;
  logic          RST;
  logic          a_req, b_req;
  logic [AW-1:0] a_wsel, b_wsel;
  logic [DW-1:0] a_wdat, b_wdat;
  logic          a_gnt, b_gnt;
  logic          init_busy, WEN;
  logic [AW-1:0] wsel;
  logic [DW-1:0] wdat;
  logic          state_dbg;

  // Expected entry: {check_data, init_busy, WEN, wsel, wdat}
  logic [AW+DW+2:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_phase;
  logic [AW-1:0] m_cnt;
  logic          m_last_b;
  logic [AW-1:0] m_wsel;
  logic [DW-1:0] m_wdat;
  logic          m_a_gnt, m_b_gnt;

  regfile_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_wsel(a_wsel), .a_wdat(a_wdat), .a_gnt(a_gnt),
    .b_req(b_req), .b_wsel(b_wsel), .b_wdat(b_wdat), .b_gnt(b_gnt),
    .init_busy(init_busy), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .state_dbg(state_dbg)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic chk, input logic busy, input logic wen,
                          input logic [AW-1:0] s, input logic [DW-1:0] d);
    exp_q.push_back({chk, busy, wen, s, d});
  endtask

  // One clock cycle: compare outputs against last cycle's prediction, predict
  // this cycle's grants and next cycle's outputs, then advance past the edge.
  task automatic step();
    logic [AW+DW+2:0] e;
    logic ea, eb;
    logic [AW-1:0] s;
    logic [DW-1:0] d;
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("init_busy", 64'(init_busy), 64'(e[AW+DW+1]));
      check("wen", 64'(WEN), 64'(e[AW+DW]));
      if (e[AW+DW+2]) begin
        check("wsel", 64'(wsel), 64'(e[AW+DW-1:DW]));
        check("wdat", 64'(wdat), 64'(e[DW-1:0]));
      end
    end
    ea = 1'b0;
    eb = 1'b0;
    if (RST) begin
      m_phase  = P_INIT;
      m_cnt    = AW'(1);
      m_last_b = 1'b1;
      m_wsel   = '0;
      m_wdat   = '0;
      push_exp(1'b1, 1'b0, 1'b0, '0, '0);
    end else begin
      case (m_phase)
        P_INIT: begin
          push_exp(1'b1, 1'b1, 1'b1, m_cnt, '0);
          m_wsel = m_cnt;
          m_wdat = '0;
          if (int'(m_cnt) == NREG - 1) m_phase = P_DRAIN;
          else m_cnt = m_cnt + AW'(1);
        end
        P_DRAIN: begin
          push_exp(1'b1, 1'b0, 1'b0, m_wsel, m_wdat);
          m_phase = P_ARB;
        end
        default: begin
          ea = a_req && (!b_req || m_last_b);
          eb = b_req && !ea;
          if (ea || eb) begin
            s = ea ? a_wsel : b_wsel;
            d = ea ? a_wdat : b_wdat;
            m_last_b = eb;
            if (s != '0) begin
              push_exp(1'b1, 1'b0, 1'b1, s, d);
              m_wsel = s;
              m_wdat = d;
            end else begin
              push_exp(1'b0, 1'b0, 1'b0, '0, '0);
            end
          end else begin
            push_exp(1'b1, 1'b0, 1'b0, m_wsel, m_wdat);
          end
        end
      endcase
    end
    check("a_gnt", 64'(a_gnt), 64'(ea));
    check("b_gnt", 64'(b_gnt), 64'(eb));
    m_a_gnt = ea;
    m_b_gnt = eb;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    m_phase = P_INIT; m_cnt = AW'(1); m_last_b = 1'b1;
    m_wsel = '0; m_wdat = '0; m_a_gnt = 1'b0; m_b_gnt = 1'b0;

    // Reset sweep with both requesters already asserting, then contention on reg 7.
    RST = 1'b1;
    a_req = 1'b1; a_wsel = AW'(7); a_wdat = 32'h0000_000A;
    b_req = 1'b1; b_wsel = AW'(7); b_wdat = 32'h0000_000B;
    repeat (2) step();
    RST = 1'b0;
    repeat (37) step();

    // Idle: WEN drops, sel/data hold.
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) step();

    // Single write from A.
    a_req = 1'b1; a_wsel = AW'(5); a_wdat = 32'h0000_1234;
    step();
    a_req = 1'b0;
    repeat (2) step();

    // Write to register zero from B is consumed without a write.
    b_req = 1'b1; b_wsel = '0; b_wdat = 32'hFFFF_FFFF;
    step();
    b_req = 1'b0;
    repeat (2) step();

    // Random traffic; each request held stable until granted.
    for (int i = 0; i < 300; i++) begin
      if (!a_req || m_a_gnt) begin
        a_req  = ($urandom_range(0, 3) != 0);
        a_wsel = AW'($urandom_range(0, NREG - 1));
        a_wdat = $urandom;
      end
      if (!b_req || m_b_gnt) begin
        b_req  = ($urandom_range(0, 3) != 0);
        b_wsel = AW'($urandom_range(0, NREG - 1));
        b_wdat = $urandom;
      end
      step();
    end

    // Reset mid-sweep at register 10, then a full sweep.
    a_req = 1'b0; b_req = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_phase == P_INIT && int'(m_cnt) == 10) break;
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (36) step();

    // Reset in the cycle A would be granted: no write emitted.
    a_req = 1'b1; a_wsel = AW'(9); a_wdat = 32'hDEAD_BEEF;
    RST = 1'b1;
    step();
    RST = 1'b0;
    a_req = 1'b0;
    repeat (36) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
